pll_reset_sequencer: RTL and testbench

//  Sequences the system PLL (96/32 MHz outputs) from the 50 MHz reference clock.

---
 rtl/pll_reset_sequencer_if.sv | 37 +++
 rtl/pll_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// PLL reset sequencer signal bundle.
// Groups the PLL/system-facing signals of pll_reset_sequencer so they travel together.
//   locked       PLL lock indication (asynchronous to refclk)
//   relock_req   single-cycle software relock pulse
//   pll_rst      reset to the PLL
//   sys_rst      active-high core reset, low only when running
//   ready        high only when running
//   relock_count saturating re-sequence count
// Modports:
//   master  the sequencer (drives pll_rst/sys_rst/ready/relock_count)
//   slave   the PLL / system side (drives locked/relock_req)
interface pll_reset_sequencer_if;
    logic       locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;

    modport master (
        input  locked,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output relock_count
    );

    modport slave (
        output locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  relock_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Holds the PLL in reset for PLL_RST_CYCLES, waits up to LOCK_TIMEOUT cycles for lock
// (retrying forever), then requires SETTLE_CYCLES consecutive synchronised lock cycles
// before releasing the core reset. Loss of lock or a relock request re-sequences.
// Ports:
//   refclk  reference clock, sole clock
//   rst     synchronous active-high reset
//   bus     pll_reset_sequencer_if.master: locked, relock_req in;
//           pll_rst, sys_rst, ready, relock_count out
// Optional feature: define PLL_SEQ_RELOCK_COUNT_EN to enable the saturating relock_count;
// otherwise relock_count is tied to zero. FSM timing is identical in both builds.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned SETTLE_CYCLES  = 1024
) (
    input logic                   refclk,
    input logic                   rst,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned MaxAb     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                          : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles = (MaxAb > SETTLE_CYCLES) ? MaxAb : SETTLE_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StReset,
        StWaitLock,
        StSettle,
        StRun
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      sync_q;
    logic            locked_s;

    assign locked_s = sync_q[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= StReset;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.locked};
            if (bus.relock_req) begin
                // Also restarts the hold time when already in reset.
                state_q <= StReset;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StReset: begin
                        if (cnt_q == RstLast) begin
                            state_q <= StWaitLock;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitLock: begin
                        if (locked_s) begin
                            state_q <= StSettle;
                            cnt_q   <= '0;
                        end else if (cnt_q == TimeoutLast) begin
                            state_q <= StReset;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StSettle: begin
                        if (!locked_s) begin
                            // Timeout window restarts from zero.
                            state_q <= StWaitLock;
                            cnt_q   <= '0;
                        end else if (cnt_q == SettleLast) begin
                            state_q <= StRun;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StRun: begin
                        cnt_q <= '0;
                        if (!locked_s) begin
                            state_q <= StReset;
                        end
                    end
                    default: begin
                        state_q <= StReset;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Decoded from the state register only so the outputs cannot glitch.
    assign bus.pll_rst = (state_q == StReset);
    assign bus.sys_rst = (state_q != StRun);
    assign bus.ready   = (state_q == StRun);

`ifdef PLL_SEQ_RELOCK_COUNT_EN
    logic [7:0] relock_count_q;
    logic       relock_event;

    // Retry, lock loss, or a relock request accepted outside reset.
    always_comb begin
        relock_event = 1'b0;
        if (bus.relock_req) begin
            relock_event = (state_q != StReset);
        end else if (state_q == StWaitLock) begin
            relock_event = !locked_s && (cnt_q == TimeoutLast);
        end else if (state_q == StRun) begin
            relock_event = !locked_s;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_count_q <= 8'd0;
        end else if (relock_event && (relock_count_q != 8'hFF)) begin
            relock_count_q <= relock_count_q + 8'd1;
        end
    end

    assign bus.relock_count = relock_count_q;
`else
    assign bus.relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// SETTLE_CYCLES=8). Expected values are pushed to a scoreboard queue as stimulus is
// driven and popped when the DUT produces the corresponding output.
// Works with or without PLL_SEQ_RELOCK_COUNT_EN defined.
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_RELOCK_COUNT_EN
    localparam bit RcEn = 1'b1;
`else
    localparam bit RcEn = 1'b0;
`endif

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    int   exp_rc   = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .SETTLE_CYCLES (8)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.pll_rst;
            1:       return bus.ready;
            default: return bus.sys_rst;
        endcase
    endfunction

    // Ticks until the selected output equals want; at = cycle seen, or -1 on timeout.
    task automatic wait_sig(input int sel, input logic want, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (sig(sel) === want) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int rc_inc(input int v);
        return RcEn ? ((v >= 255) ? 255 : v + 1) : 0;
    endfunction

    task automatic test_reset();
        int at, got, e;
        rst = 1'b1;
        bus.locked = 1'b0;
        bus.relock_req = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++;
            $display("FAIL reset_pll_rst: observed %b, expected 1", bus.pll_rst); end
        n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++;
            $display("FAIL reset_sys_rst: observed %b, expected 1", bus.sys_rst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready: observed %b, expected 0", bus.ready); end
        n_checks++; if (bus.relock_count !== 8'd0) begin n_fail++;
            $display("FAIL reset_count: observed %0d, expected 0", bus.relock_count); end
        rst = 1'b0;
        exp_rc = 0;
        exp_q.push_back(cyc + 4);
        wait_sig(0, 1'b0, 20, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL reset_pll_rst_width: observed fall %0d, expected %0d", at, got); end
        repeat (3) tick();
        e = cyc;
        bus.locked = 1'b1;
        exp_q.push_back(e + 1 + 10);
        wait_sig(1, 1'b1, 40, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL first_ready: observed %0d, expected %0d", at, got); end
        n_checks++; if (bus.sys_rst !== 1'b0) begin n_fail++;
            $display("FAIL first_sys_rst: observed %b, expected 0", bus.sys_rst); end
    endtask

    task automatic test_timeout_retry();
        int at, got, fall;
        logic sys_low;
        bus.locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_rc = 0;
        exp_q.push_back(cyc + 4);
        wait_sig(0, 1'b0, 20, fall);
        got = exp_q.pop_front();
        n_checks++; if (fall !== got) begin n_fail++;
            $display("FAIL retry_first_fall: observed %0d, expected %0d", fall, got); end
        sys_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(fall + 32);
            for (int j = 0; j < 100; j++) begin
                tick();
                if (bus.sys_rst !== 1'b1) sys_low = 1'b1;
                if (bus.pll_rst === 1'b1) break;
            end
            at = (bus.pll_rst === 1'b1) ? cyc : -1;
            got = exp_q.pop_front();
            n_checks++; if (at !== got) begin n_fail++;
                $display("FAIL retry_rise_%0d: observed %0d, expected %0d", i, at, got); end
            exp_rc = rc_inc(exp_rc);
            n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
                $display("FAIL retry_count_%0d: observed %0d, expected %0d", i,
                         bus.relock_count, exp_rc); end
            exp_q.push_back(at + 4);
            wait_sig(0, 1'b0, 20, fall);
            got = exp_q.pop_front();
            n_checks++; if (fall !== got) begin n_fail++;
                $display("FAIL retry_width_%0d: observed fall %0d, expected %0d", i, fall, got); end
        end
        n_checks++; if (sys_low !== 1'b0) begin n_fail++;
            $display("FAIL retry_sys_rst_held: observed low=%b, expected 0", sys_low); end
    endtask

    task automatic test_settle_glitch();
        int at, got, k;
        logic pulse_seen;
        repeat (2) tick();
        bus.locked = 1'b1;
        k = cyc + 1;
        while (cyc < k + 5) tick();
        bus.locked = 1'b0;  // seen by the FSM at SETTLE cnt=5
        repeat (3) tick();
        bus.locked = 1'b1;
        exp_q.push_back(cyc + 1 + 10);
        pulse_seen = 1'b0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.pll_rst !== 1'b0) pulse_seen = 1'b1;
            if (bus.ready === 1'b1) begin
                at = cyc;
                break;
            end
        end
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL glitch_ready: observed %0d, expected %0d", at, got); end
        n_checks++; if (pulse_seen !== 1'b0) begin n_fail++;
            $display("FAIL glitch_no_pll_rst: observed pulse=%b, expected 0", pulse_seen); end
    endtask

    task automatic test_lock_loss();
        int at, got, e;
        tick();
        e = cyc;
        bus.locked = 1'b0;
        exp_q.push_back(e + 3);
        wait_sig(1, 1'b0, 10, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL loss_ready_drop: observed %0d, expected %0d", at, got); end
        n_checks++; if (bus.sys_rst !== 1'b1 || bus.pll_rst !== 1'b1) begin n_fail++;
            $display("FAIL loss_resets: observed sys=%b pll=%b, expected 1 1",
                     bus.sys_rst, bus.pll_rst); end
        exp_rc = rc_inc(exp_rc);
        n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
            $display("FAIL loss_count: observed %0d, expected %0d", bus.relock_count, exp_rc); end
        exp_q.push_back(e + 7);
        wait_sig(0, 1'b0, 10, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL loss_pll_rst_width: observed fall %0d, expected %0d", at, got); end
        tick();
        bus.locked = 1'b1;
        exp_q.push_back(cyc + 1 + 10);
        wait_sig(1, 1'b1, 40, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL loss_reready: observed %0d, expected %0d", at, got); end
    endtask

    task automatic test_relock_req();
        int at, got, e;
        tick();
        e = cyc;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_checks++; if (bus.pll_rst !== 1'b1 || bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL req_immediate: observed pll=%b ready=%b, expected 1 0",
                     bus.pll_rst, bus.ready); end
        exp_rc = rc_inc(exp_rc);
        n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
            $display("FAIL req_count: observed %0d, expected %0d", bus.relock_count, exp_rc); end
        repeat (2) tick();
        bus.relock_req = 1'b1;  // sampled while RESET cnt=2
        tick();
        bus.relock_req = 1'b0;
        exp_q.push_back(e + 8);  // 7 cycles high starting at e+1
        wait_sig(0, 1'b0, 20, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL req_hold_restart: observed fall %0d, expected %0d", at, got); end
        n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
            $display("FAIL req_in_reset_count: observed %0d, expected %0d",
                     bus.relock_count, exp_rc); end
        exp_q.push_back(e + 17);
        wait_sig(1, 1'b1, 40, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL req_ready: observed %0d, expected %0d", at, got); end
    endtask

    task automatic test_saturate();
        int at, timeouts;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            bus.locked = 1'b0;
            wait_sig(2, 1'b1, 10, at);
            if (at < 0) timeouts++;
            exp_rc = rc_inc(exp_rc);
            bus.locked = 1'b1;
            wait_sig(1, 1'b1, 60, at);
            if (at < 0) timeouts++;
        end
        n_checks++; if (timeouts !== 0) begin n_fail++;
            $display("FAIL sat_sequence: observed %0d timeouts, expected 0", timeouts); end
        n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
            $display("FAIL sat_count: observed %0d, expected %0d", bus.relock_count, exp_rc); end
    endtask

    task automatic test_rst_mid_settle();
        int at, got, r;
        tick();
        bus.locked = 1'b0;
        wait_sig(0, 1'b1, 10, at);
        wait_sig(0, 1'b0, 10, at);
        tick();
        bus.locked = 1'b1;
        repeat (5) tick();  // FSM now in SETTLE
        rst = 1'b1;
        tick();
        exp_rc = 0;
        n_checks++; if (bus.pll_rst !== 1'b1) begin n_fail++;
            $display("FAIL mid_rst_pll_rst: observed %b, expected 1", bus.pll_rst); end
        n_checks++; if (bus.sys_rst !== 1'b1) begin n_fail++;
            $display("FAIL mid_rst_sys_rst: observed %b, expected 1", bus.sys_rst); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_ready: observed %b, expected 0", bus.ready); end
        n_checks++; if (int'(bus.relock_count) !== exp_rc) begin n_fail++;
            $display("FAIL mid_rst_count: observed %0d, expected %0d", bus.relock_count, exp_rc); end
        rst = 1'b0;
        r = cyc;
        exp_q.push_back(r + 4);
        exp_q.push_back(r + 13);
        wait_sig(0, 1'b0, 20, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL mid_rst_pll_fall: observed %0d, expected %0d", at, got); end
        wait_sig(1, 1'b1, 40, at);
        got = exp_q.pop_front();
        n_checks++; if (at !== got) begin n_fail++;
            $display("FAIL mid_rst_ready_rise: observed %0d, expected %0d", at, got); end
    endtask

    initial begin
        bus.locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_timeout_retry();
        test_settle_glitch();
        test_lock_loss();
        test_relock_req();
        test_saturate();
        test_rst_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
